// File: rtl/axis_pack_fifo.sv
// AXI-Stream packer with a first-word-fall-through FIFO and an optional
// start-of-frame hunt mode that discards beats until the first tuser[0].
module axis_pack_fifo #(
    parameter int TDATA_WIDTH = 32,
    parameter int TUSER_WIDTH = 1,
    parameter int DEPTH       = 4,
    parameter int SYNC_SOF    = 1
) (
    input  logic                               i_clk,
    input  logic                               i_rstn,
    input  logic                               i_tvalid,
    output logic                               o_tready,
    input  logic [TDATA_WIDTH-1:0]             i_tdata,
    input  logic [TUSER_WIDTH-1:0]             i_tuser,
    input  logic                               i_tlast,
    input  logic                               i_resync,
    output logic                               o_tvalid,
    input  logic                               i_tready,
    output logic [TDATA_WIDTH+TUSER_WIDTH:0]   o_tpacked,
    output logic [$clog2(DEPTH):0]             o_level,
    output logic [15:0]                        o_drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = TDATA_WIDTH + TUSER_WIDTH + 1;

    typedef enum logic {
        PASS = 1'b0,
        HUNT = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [PW-1:0] mem [DEPTH];
    logic          full;
    logic          empty;
    logic          wr;
    logic          rd;
    logic          sof;
    logic          store;
    logic          drop;

    // Wrap bit differs with equal index bits: writer is a full lap ahead.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign o_tready  = !full;
    assign o_tvalid  = !empty;
    assign wr        = i_tvalid && o_tready;
    assign rd        = o_tvalid && i_tready;
    assign sof       = i_tuser[0];
    assign o_tpacked = mem[rd_ptr[AW-1:0]];
    assign o_level   = wr_ptr - rd_ptr;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state <= (SYNC_SOF != 0) ? HUNT : PASS;
        end else begin
            state <= state_nxt;
        end
    end

    // A resync request overrides a SOF that lands in the same cycle.
    always_comb begin
        state_nxt = state;
        if (i_resync) begin
            state_nxt = HUNT;
        end else if (state == HUNT && wr && sof) begin
            state_nxt = PASS;
        end
    end

    always_comb begin
        store = 1'b0;
        drop  = 1'b0;
        unique case (state)
            PASS: store = wr;
            HUNT: begin
                store = wr && sof;
                drop  = wr && !sof;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (store) begin
            mem[wr_ptr[AW-1:0]] <= {i_tdata, i_tuser, i_tlast};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            o_drop_cnt <= '0;
        end else if (drop && o_drop_cnt != 16'hFFFF) begin
            o_drop_cnt <= o_drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_axis_pack_fifo.sv
// Scoreboard bench for axis_pack_fifo: queue-based reference model,
// directed scenarios plus a randomized stretch.
module tb_axis_pack_fifo;

    localparam int TDW      = 32;
    localparam int TUW      = 1;
    localparam int DEPTH    = 4;
    localparam int SYNC_SOF = 1;
    localparam int PW       = TDW + TUW + 1;
    localparam int LW       = $clog2(DEPTH) + 1;

    logic           i_clk    = 1'b0;
    logic           i_rstn   = 1'b0;
    logic           i_tvalid = 1'b0;
    logic [TDW-1:0] i_tdata  = '0;
    logic [TUW-1:0] i_tuser  = '0;
    logic           i_tlast  = 1'b0;
    logic           i_resync = 1'b0;
    logic           i_tready = 1'b0;
    logic           o_tready;
    logic           o_tvalid;
    logic [PW-1:0]  o_tpacked;
    logic [LW-1:0]  o_level;
    logic [15:0]    o_drop_cnt;

    axis_pack_fifo #(
        .TDATA_WIDTH(TDW),
        .TUSER_WIDTH(TUW),
        .DEPTH      (DEPTH),
        .SYNC_SOF   (SYNC_SOF)
    ) dut (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_tvalid  (i_tvalid),
        .o_tready  (o_tready),
        .i_tdata   (i_tdata),
        .i_tuser   (i_tuser),
        .i_tlast   (i_tlast),
        .i_resync  (i_resync),
        .o_tvalid  (o_tvalid),
        .i_tready  (i_tready),
        .o_tpacked (o_tpacked),
        .o_level   (o_level),
        .o_drop_cnt(o_drop_cnt)
    );

    always #5 i_clk = ~i_clk;

    int            vectors     = 0;
    int            miscompares = 0;
    logic [PW-1:0] exp_q[$];
    bit            hunt        = 1'b0;
    int            drops       = 0;
    bit            started     = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, req, $time);
        end
    endtask

    function automatic int sat_drops();
        return (drops > 65535) ? 65535 : drops;
    endfunction

    // Reference model: accepted beats are stored unless hunting for a SOF.
    always @(posedge i_clk) begin
        if (!i_rstn) begin
            exp_q.delete();
            hunt  = (SYNC_SOF != 0);
            drops = 0;
        end else begin
            if (i_tvalid && o_tready) begin
                if (!hunt || i_tuser[0]) begin
                    exp_q.push_back({i_tdata, i_tuser, i_tlast});
                end else begin
                    drops++;
                end
            end
            if (i_resync) begin
                hunt = 1'b1;
            end else if (i_tvalid && o_tready && i_tuser[0]) begin
                hunt = 1'b0;
            end
        end
    end

    // Output monitor: every consumed word must match the model's head.
    always @(posedge i_clk) begin
        if (started && i_rstn && o_tvalid && i_tready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL pop_empty: got word %0h expected none at %0t",
                         o_tpacked, $time);
            end else begin
                chk("pop_word", o_tpacked, exp_q.pop_front());
            end
        end
    end

    // Status outputs against model occupancy, sampled mid-cycle.
    always @(negedge i_clk) begin
        if (started) begin
            chk("tvalid", o_tvalid, exp_q.size() != 0);
            chk("tready", o_tready, exp_q.size() < DEPTH);
            chk("level", o_level, exp_q.size());
            chk("drop_cnt", o_drop_cnt, sat_drops());
            if (exp_q.size() != 0) begin
                chk("head", o_tpacked, exp_q[0]);
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push_n(input int n, input logic [31:0] base);
        int k = 0;
        bit acc;
        for (int c = 0; c < 4 * n + 8 && k < n; c++) begin
            i_tvalid = 1'b1;
            i_tdata  = base + k;
            i_tuser  = '0;
            i_tlast  = (k == n - 1);
            acc      = o_tready;
            step();
            if (acc) k++;
        end
        i_tvalid = 1'b0;
        chk("push_done", k, n);
    endtask

    task automatic drain();
        i_tvalid = 1'b0;
        i_tready = 1'b1;
        for (int c = 0; c < 20 && o_tvalid; c++) step();
        chk("drain_empty", o_tvalid, 1'b0);
    endtask

    initial begin
        int k;
        bit acc;
        int base;

        // Reset
        i_rstn = 1'b0;
        step();
        step();
        started = 1'b1;
        i_rstn  = 1'b1;
        chk("rst_tready", o_tready, 1'b1);
        chk("rst_tvalid", o_tvalid, 1'b0);

        // Reset then stream: three dropped beats, then a SOF
        i_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_tvalid = 1'b1;
            i_tdata  = 32'h10 + i;
            i_tuser  = '0;
            i_tlast  = 1'b0;
            step();
        end
        i_tdata = 32'hA5;
        i_tuser = 1'b1;
        chk("sof_not_same_cycle", o_tvalid, 1'b0);
        step();
        i_tvalid = 1'b0;
        i_tuser  = '0;
        chk("sof_latency", o_tvalid, 1'b1);
        chk("first_word", o_tpacked, {32'hA5, 1'b1, 1'b0});
        chk("drop3", o_drop_cnt, 3);
        step();

        // Fill and back-pressure with six beats
        i_tready = 1'b0;
        k = 0;
        for (int c = 0; c < 20 && k < 4; c++) begin
            i_tvalid = 1'b1;
            i_tdata  = 32'h100 + k;
            i_tuser  = '0;
            i_tlast  = 1'b0;
            acc      = o_tready;
            step();
            if (acc) k++;
        end
        i_tdata = 32'h100 + k;
        step();
        step();
        chk("full_tready", o_tready, 1'b0);
        chk("full_level", o_level, 4);
        i_tready = 1'b1;
        for (int c = 0; c < 20 && k < 6; c++) begin
            i_tvalid = 1'b1;
            i_tdata  = 32'h100 + k;
            i_tlast  = (k == 5);
            acc      = o_tready;
            step();
            if (acc) k++;
        end
        chk("fill_sent", k, 6);
        drain();

        // Steady push and pop at level 2
        i_tready = 1'b0;
        push_n(2, 32'h200);
        i_tready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            i_tvalid = 1'b1;
            i_tdata  = 32'h300 + c;
            i_tlast  = c[0];
            step();
            chk("steady_level", o_level, 2);
        end
        drain();

        // Randomized traffic including SOFs and resync pulses
        for (int c = 0; c < 400; c++) begin
            i_tvalid = ($urandom_range(0, 3) != 0);
            i_tready = ($urandom_range(0, 2) != 0);
            i_tdata  = $urandom;
            i_tuser  = ($urandom_range(0, 7) == 0);
            i_tlast  = $urandom_range(0, 1);
            i_resync = ($urandom_range(0, 39) == 0);
            step();
        end
        i_resync = 1'b0;
        i_tuser  = '0;
        drain();

        // Resync mid-frame
        i_tvalid = 1'b1;
        i_tdata  = 32'h5A;
        i_tuser  = 1'b1;
        step();
        i_tvalid = 1'b0;
        i_tuser  = '0;
        drain();
        i_tready = 1'b0;
        push_n(3, 32'h400);
        base     = drops;
        i_resync = 1'b1;
        step();
        i_resync = 1'b0;
        chk("resync_keep", o_level, 3);
        i_tready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            i_tvalid = 1'b1;
            i_tdata  = 32'h500 + i;
            i_tuser  = '0;
            step();
        end
        chk("resync_drops", o_drop_cnt, base + 2);
        i_tdata = 32'hC3;
        i_tuser = 1'b1;
        step();
        i_tvalid = 1'b0;
        i_tuser  = '0;
        drain();

        // Reset mid-operation
        i_tready = 1'b0;
        push_n(3, 32'h600);
        chk("pre_rst_level", o_level, 3);
        i_rstn = 1'b0;
        step();
        i_rstn = 1'b1;
        chk("rst2_tvalid", o_tvalid, 1'b0);
        chk("rst2_level", o_level, 0);
        chk("rst2_tready", o_tready, 1'b1);
        chk("rst2_drop", o_drop_cnt, 0);

        // Drop counter saturation
        i_tready = 1'b1;
        i_tvalid = 1'b1;
        i_tuser  = '0;
        for (int c = 0; c < 65540; c++) begin
            i_tdata = c;
            step();
        end
        i_tvalid = 1'b0;
        step();
        chk("saturate", o_drop_cnt, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
